// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, auto-reload and abort.
// Counts a captured start value down to zero and pulses expired_o at terminal count.
module countdown_timer #(
    parameter int WIDTH          = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [WIDTH-1:0]          load_value_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      auto_reload_i,
    input  logic                      abort_i,
    output logic [WIDTH-1:0]          counter_value_o,
    output logic                      busy_o,
    output logic                      expired_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]                state_q,   state_d;
    logic [WIDTH-1:0]          count_q,   count_d;
    logic [WIDTH-1:0]          reload_q,  reload_d;
    logic [PRESCALE_WIDTH-1:0] pre_q,     pre_d;
    logic [PRESCALE_WIDTH-1:0] pre_max_q, pre_max_d;
    logic                      auto_q,    auto_d;
    logic                      expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        pre_d     = pre_q;
        pre_max_d = pre_max_q;
        auto_d    = auto_q;
        expired_d = 1'b0;

        if (state_q == IDLE) begin
            if (load_valid_i) begin
                count_d   = load_value_i;
                reload_d  = load_value_i;
                pre_max_d = prescale_i;
                auto_d    = auto_reload_i;
                pre_d     = '0;
                // A zero start value expires immediately and is never reloaded.
                if (load_value_i != '0) begin
                    state_d = RUN;
                end else begin
                    expired_d = 1'b1;
                end
            end
        end else begin
            if (abort_i) begin
                state_d = IDLE;
                count_d = '0;
                pre_d   = '0;
            end else if (enable_i) begin
                if (pre_q >= pre_max_q) begin
                    pre_d = '0;
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // Terminal count: also catches a stray zero so count never wraps.
                        expired_d = 1'b1;
                        if (auto_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    pre_d = pre_q + PRESCALE_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            pre_q     <= '0;
            pre_max_q <= '0;
            auto_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            pre_q     <= pre_d;
            pre_max_q <= pre_max_d;
            auto_q    <= auto_d;
            expired_q <= expired_d;
        end
    end

    assign load_ready_o    = (state_q == IDLE);
    assign busy_o          = (state_q == RUN);
    assign counter_value_o = count_q;
    assign expired_o       = expired_q;

endmodule
